// File: rtl/icl_link_pkg.sv
// Shared definitions for the inter-core link endpoints.
// Holds the default link word width, the bit positions of the REQ/ACK/ready
// flags inside the ack words, the handshake FSM state type and the field
// offsets of the receive status word. No ports.
package icl_link_pkg;

  localparam int LINK_W = 14;

  // Handshake bit positions inside the ack words.
  localparam int REQ_BIT = 0;
  localparam int ACK_BIT = 0;
  localparam int RDY_BIT = 1;

  // Status word layout: {pad, overflow_sticky, full, count, rd_valid}.
  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_CNT_LSB   = 1;

  typedef enum logic [0:0] {
    WAIT_REQ = 1'b0,
    ACK_HI   = 1'b1
  } link_state_e;

  // count occupies clog2(depth)+1 bits, so full sits directly above it.
  function automatic int stat_full_bit(input int depth);
    return STAT_CNT_LSB + $clog2(depth) + 1;
  endfunction

  function automatic int stat_ovf_bit(input int depth);
    return stat_full_bit(depth) + 1;
  endfunction

endpackage

// File: rtl/icl_link_rx_if.sv
// Signal bundle between the link receive endpoint, its peer and the local core.
// master: the side driving the peer words, rd_pop and clr_err (peer + core).
// slave : the receive endpoint.
// Signals: link_ack_in, link_data_in, link_ack_out, rd_pop, rd_data,
//          rd_valid, status, clr_err.
interface icl_link_rx_if #(
  parameter int LINK_W = icl_link_pkg::LINK_W
);
  logic [LINK_W-1:0] link_ack_in;
  logic [LINK_W-1:0] link_data_in;
  logic [LINK_W-1:0] link_ack_out;
  logic              rd_pop;
  logic [LINK_W-1:0] rd_data;
  logic              rd_valid;
  logic [LINK_W-1:0] status;
  logic              clr_err;

  modport master (
    output link_ack_in, link_data_in, rd_pop, clr_err,
    input  link_ack_out, rd_data, rd_valid, status
  );

  modport slave (
    input  link_ack_in, link_data_in, rd_pop, clr_err,
    output link_ack_out, rd_data, rd_valid, status
  );
endinterface

// File: rtl/icl_sync_fifo.sv
// Single-clock circular FIFO, shared by the link receive and transmit sides.
// Ports: clk_i, rst_i (sync, active-high), push_i/din_i write, pop_i read,
//        dout_o head word (0 when empty), count_o occupancy, full_o, empty_o.
// DEPTH must be a power of two >= 2 so pointers wrap by natural overflow.
module icl_sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  import icl_link_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Count never exceeds DEPTH = 2**AW, so its MSB alone marks full.
  assign full_o  = count_q[AW];
  assign empty_o = (count_q == {(AW+1){1'b0}});
  assign count_o = count_q;

  // Pointer and occupancy next-state; illegal push/pop are dropped here.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while not counted.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Head word, forced to zero when nothing is buffered.
  always_comb begin
    if (empty_o) begin
      dout_o = {WIDTH{1'b0}};
    end else begin
      dout_o = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/icl_link_rx.sv
// Receive endpoint of the inter-core link (responder of the four-phase
// REQ/ACK handshake). Registers the peer's REQ and data, pushes each new word
// into a FIFO once per handshake, returns ACK/ready to the peer and presents
// the head word plus a status word to the local core.
// Ports: Clock_pin, Reset_pin (sync, active-high), link_if (slave modport:
//        link_ack_in, link_data_in, link_ack_out, rd_pop, rd_data, rd_valid,
//        status, clr_err).
module icl_link_rx #(
  parameter int LINK_W = 14,
  parameter int DEPTH  = 4
) (
  input  logic          Clock_pin,
  input  logic          Reset_pin,
  icl_link_rx_if.slave  link_if
);
  import icl_link_pkg::*;

  localparam int CW       = $clog2(DEPTH);
  localparam int FULL_BIT = stat_full_bit(DEPTH);
  localparam int OVF_BIT  = stat_ovf_bit(DEPTH);

  logic              req_q;
  logic [LINK_W-1:0] data_q;
  link_state_e       state_q, state_d;
  logic              ack_q, ack_d;
  logic              ovf_q, ovf_d;
  logic              push, ovf_set;
  logic [LINK_W-1:0] fifo_dout;
  logic [CW:0]       fifo_count;
  logic              fifo_full, fifo_empty;
  logic              unused_ack_bits;

  // Only REQ is meaningful in the peer's ack word.
  assign unused_ack_bits = ^link_if.link_ack_in[LINK_W-1:1];

  icl_sync_fifo #(.WIDTH(LINK_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (Clock_pin),
    .rst_i   (Reset_pin),
    .push_i  (push),
    .pop_i   (link_if.rd_pop),
    .din_i   (data_q),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Input capture plus FSM, ACK and sticky-error registers.
  always_ff @(posedge Clock_pin) begin
    if (Reset_pin) begin
      req_q   <= 1'b0;
      data_q  <= {LINK_W{1'b0}};
      state_q <= WAIT_REQ;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      req_q   <= link_if.link_ack_in[REQ_BIT];
      data_q  <= link_if.link_data_in;
      state_q <= state_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake FSM: one push per REQ pulse, ACK held until REQ drops.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      WAIT_REQ: begin
        ack_d = 1'b0;
        if (req_q && !fifo_full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK_HI;
        end else if (req_q) begin
          // Backpressure: withhold ACK; the peer keeps REQ until space frees.
          ovf_set = 1'b1;
        end else begin
          state_d = WAIT_REQ;
        end
      end
      ACK_HI: begin
        if (!req_q) begin
          ack_d   = 1'b0;
          state_d = WAIT_REQ;
        end else begin
          ack_d   = 1'b1;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = WAIT_REQ;
      end
    endcase
  end

  // Sticky overflow flag; a set in the same cycle as a clear takes priority.
  always_comb begin
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (link_if.clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Output words, built only from registered state.
  always_comb begin
    link_if.link_ack_out          = {LINK_W{1'b0}};
    link_if.link_ack_out[ACK_BIT] = ack_q;
    link_if.link_ack_out[RDY_BIT] = !fifo_full;
    link_if.rd_data               = fifo_dout;
    link_if.rd_valid              = !fifo_empty;
    link_if.status                = {LINK_W{1'b0}};
    link_if.status[STAT_VALID_BIT]         = !fifo_empty;
    link_if.status[STAT_CNT_LSB +: CW + 1] = fifo_count;
    link_if.status[FULL_BIT]               = fifo_full;
    link_if.status[OVF_BIT]                = ovf_q;
  end

endmodule

// File: doc/icl_link_rx.md
# icl_link_rx

Hardware receive endpoint for the inter-core link, the responder side of the 14-bit data/ack handshake a peer core drives from its Out ports. It watches the peer's ack word (REQ) and data word and captures each word into a small FIFO. It returns an acknowledge word to the peer and presents buffered words and a status word to the local core's In ports. One instance sits between a `coreKto0_*` / `core0toK_*` wire pair and the local core.

## Interface
Parameters:
- LINK_W, 14: width of the link data and ack words.
- DEPTH, 4: number of FIFO entries; must be a power of two, at least 2.

Ports (clock and reset first):
- Clock_pin  in  1  system clock; the only clock.
- Reset_pin  in  1  reset, synchronous and active-high.
- link_ack_in  in  LINK_W  peer's ack word; bit 0 = REQ; other bits ignored.
- link_data_in  in  LINK_W  peer's data word.
- link_ack_out  out  LINK_W  to the peer's In port. Bit 0 = ACK, bit 1 = ready (FIFO not full), bits 13:2 = 0.
- rd_pop  in  1  local core consumes the head word.
- rd_data  out  LINK_W  head-of-FIFO word; 0 when empty.
- rd_valid  out  1  FIFO not empty.
- status  out  LINK_W  {zero pad, overflow_sticky, full, count[clog2(DEPTH):0], rd_valid}.
- clr_err  in  1  clears overflow_sticky.

## Operation
Input registering:
- link_ack_in[0] and link_data_in are registered once into req_q / data_q each cycle.
- All control uses only req_q and data_q.

Four-phase FSM:
- **WAIT_REQ**: if req_q=1 and FIFO not full, push data_q, set ACK=1, go to ACK_HI. If req_q=1 and FIFO full, stay with ACK=0 (backpressure) and set overflow_sticky.
- **ACK_HI**: hold ACK=1 until req_q=0, then clear ACK and return to WAIT_REQ. req_q staying 1 never causes a second push.

Peer obligations:
- data must be stable no later than the cycle REQ rises.
- data must be held until the peer sees ACK=1.
- These rules are not checked.

FIFO:
- Circular buffer with rd/wr pointers of clog2(DEPTH) bits, wrapping at DEPTH.
- count has clog2(DEPTH)+1 bits.
- Push and pop in the same cycle: both occur and count is unchanged.
- Pop when empty is ignored; count never underflows.
- Push is impossible when full (FSM gating), so count never exceeds DEPTH.

Error flag:
- overflow_sticky is set by REQ seen while full and cleared only by clr_err or reset.
- If set and clear happen in the same cycle, set wins.

Reset mid-handshake:
- The FSM returns to WAIT_REQ, ACK drops, and the FIFO empties.
- A peer still holding REQ=1 after reset is treated as a new request, and its word is captured once.

## Timing
- Reset values: link_ack_out = 14'h0002 (ACK=0, ready=1), rd_data = 0, rd_valid = 0, status = 0, FSM in WAIT_REQ, pointers and count = 0.
- Latency: REQ rises at the input in cycle n, req_q is seen in n+1, and ACK=1 plus rd_valid=1 appear in cycle n+2.
- REQ falls in cycle m, so ACK=0 appears in cycle m+2.
- The minimum full transfer is 4 link cycles plus the peer's software latency.
- rd_pop in cycle k updates rd_data/rd_valid/count in k+1.
- When full, a pop in cycle k allows a push in k+1 at the earliest, so ACK appears in k+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package icl_link_pkg holds:
  - LINK_W
  - REQ_BIT=0, ACK_BIT=0, RDY_BIT=1
  - FSM state enum {WAIT_REQ, ACK_HI}
  - status field offsets
- One sub-module, icl_sync_fifo (parameters WIDTH, DEPTH; push, pop, dout, count, full, empty). It is reusable for the future transmit endpoint.
- The FSM, input registers and error flag live in icl_link_rx.

## Test plan
- **Single word:** data=14'h1A5, REQ high at cycle 10. ACK=1 and rd_data=14'h1A5, rd_valid=1 at cycle 12. REQ low at 15 gives ACK=0 at 17, and count stays 1.
- **Fill and backpressure:** with DEPTH=4, send 5 words with no pops. Four ACKs are returned, full=1, the fifth REQ gets no ACK, and overflow_sticky=1. A pop then gives ACK 2 cycles later, and the FIFO holds words 2–5 in order.
- **REQ held long:** REQ held for 20 cycles pushes exactly one word, and ACK stays high until REQ falls.
- **Simultaneous push and pop:** a push and a pop land in the same cycle with count=2. count stays 2, ordering is preserved, and pointers wrap correctly after 9 transfers.
- **Reset mid-handshake:** assert Reset_pin during ACK_HI with REQ still high. Outputs take their reset values in the next cycle. After reset is released the word is captured once, count=1.
- **Error clear:** overflow_sticky=1, then pulse clr_err gives 0. Asserting clr_err in the same cycle as a new full-REQ leaves the flag at 1.
